par_gen_arb: RTL and testbench
==============================

PAR_GEN_ARB -- requirements
Module: par_gen_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-frame counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers a word.
REQ-005 SHALL have port req0_data  input  7  requester 0 payload.
REQ-006 SHALL have port req0_odd  input  1  requester 0 parity mode: 0 = even, 1 = odd.
REQ-007 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_data, req1_odd, req1_ready, identical to the requester 0 ports, for requester 1.
REQ-009 SHALL have port out_valid  output  1  framed word available.
REQ-010 SHALL have port out_data  output  8  framed word: parity bit in [7], payload in [6:0].
REQ-011 SHALL have port out_src  output  1  index of the requester that owns out_data.
REQ-012 SHALL have port out_ready  input  1  downstream consumes out_data.
REQ-013 SHALL have port frame_cnt  output  CNT_W  number of completed output transfers.

Function
REQ-014 SHALL implement FSM states IDLE, GEN and SEND.
REQ-015 In IDLE: if any reqN_valid is high, SHALL assert exactly one reqN_ready combinationally; otherwise both ready signals stay low.
REQ-016 Ready SHALL be low in GEN and SEND.
REQ-017 Grant rule: if only one requester is valid, it wins; if both are valid, the requester selected by the round-robin pointer wins.
REQ-018 Pointer SHALL move to the non-granted requester after each accept; pointer reset value selects requester 0.
REQ-019 On accept (valid && ready, cycle T): SHALL latch data, odd mode and source index into hold registers, then go IDLE -> GEN.
REQ-020 In GEN: SHALL register {parity, data} from the par_gen instance into out_data, set out_valid and out_src, then go GEN -> SEND. out_valid is therefore first high in cycle T+2.
REQ-021 Parity bit SHALL be XOR of the 7 data bits for even mode, and its inverse for odd mode; the 8-bit word then has an even (even mode) or odd (odd mode) count of ones.
REQ-022 In SEND: out_data, out_src and out_valid SHALL stay stable while out_ready is low.
REQ-023 In SEND, when out_ready is high: SHALL clear out_valid, increment frame_cnt and go SEND -> IDLE. Minimum spacing between accepts is 3 cycles.
REQ-024 frame_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturation or flag.
REQ-025 Requester data and mode are sampled only at accept; later changes SHALL NOT affect the frame in flight.
REQ-026 out_ready asserted in IDLE or GEN SHALL be ignored.

Reset
REQ-027 When rst_n is low at a rising edge: state SHALL become IDLE, out_valid 0, out_data 0, out_src 0, frame_cnt 0, pointer at requester 0 and hold registers 0.
REQ-028 Reset SHALL take priority over every other event, including a SEND handshake in the same cycle. Any frame in flight is discarded and is not counted.
REQ-029 While rst_n is low, req0_ready and req1_ready SHALL be 0.

Structure
REQ-030 State encodings and the parity-mode constants PAR_EVEN=0 and PAR_ODD=1 SHALL live in shared package par_pkg.
REQ-031 SHALL instantiate the existing combinational par_gen as its only sub-module (p = held mode, tt_in = held data, pdata = framed word). No other parity logic SHALL exist in the block.

Verification
REQ-032 Bench SHALL cover each of the following directed scenarios:
- req0 valid, data 7'h55, even, out_ready=1 -> req0_ready high at T; out_data 8'h55, out_src 0 at T+2; frame_cnt 1 after transfer.
- req1 valid, data 7'h00, odd -> out_data 8'h80, out_src 1.
- Both requesters continuously valid, out_ready=1 -> grant order 0,1,0,1, accepts 3 cycles apart.
- out_ready held low 5 cycles in SEND -> out_data and out_valid stable, both ready signals low, frame_cnt unchanged.
- rst_n low during SEND with out_ready=1 -> next cycle out_valid 0, frame_cnt 0; next grant with both requesters valid goes to requester 0.
- CNT_W=2, five transfers -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/par_pkg.sv
`default_nettype none
// ============================================================================
// Module   : par_pkg
// Purpose  : Shared definitions for the parity-framing arbiter: FSM state
//            encoding and the parity-mode constants used by par_gen and
//            par_gen_arb.
// Revision : 1.0 - initial release
// ============================================================================
package par_pkg;

  // Frame life cycle: wait for a requester, build the framed word, offer it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Parity mode selector values carried on reqN_odd / par_gen.p.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : par_pkg
`default_nettype wire

// File: rtl/par_gen.sv
`default_nettype none
// ============================================================================
// Module   : par_gen
// Purpose  : Combinational parity generator. Prepends a parity bit to a 7-bit
//            payload so that the 8-bit word has an even (p = PAR_EVEN) or odd
//            (p = PAR_ODD) number of ones.
// Ports    : p      in  1  parity mode
//            tt_in  in  7  payload
//            pdata  out 8  {parity, payload}
// Revision : 1.0 - initial release
// ============================================================================
module par_gen
  import par_pkg::*;
(
  input  logic       p,
  input  logic [6:0] tt_in,
  output logic [7:0] pdata
);

  logic w_parity;

  // Even mode: parity equals the XOR of the payload; odd mode inverts it.
  assign w_parity = (^tt_in) ^ (p == PAR_ODD);
  assign pdata    = {w_parity, tt_in};

endmodule : par_gen
`default_nettype wire

// File: rtl/par_gen_arb.sv
`default_nettype none
// ============================================================================
// Module   : par_gen_arb
// Purpose  : Two-requester round-robin arbiter that accepts one 7-bit word at
//            a time, frames it with a parity bit (par_gen) and offers it on a
//            valid/ready output port. Counts completed output transfers.
// Ports    : clk, rst_n                      clock, synchronous active-low reset
//            reqN_valid/data/odd/ready (N=0,1) requester handshakes
//            out_valid/data/src/ready         framed-word output handshake
//            frame_cnt                        completed transfers (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module par_gen_arb
  import par_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [6:0]       req0_data,
  input  logic             req0_odd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [6:0]       req1_data,
  input  logic             req1_odd,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e             state_q,     state_d;
  logic               ptr_q,       ptr_d;
  logic [6:0]         hold_data_q, hold_data_d;
  logic               hold_odd_q,  hold_odd_d;
  logic               hold_src_q,  hold_src_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q,  out_data_d;
  logic               out_src_q,   out_src_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               w_any_valid;
  logic               w_grant1;
  logic               w_idle;
  logic [7:0]         w_pdata;

  par_gen u_par_gen (
    .p     (hold_odd_q),
    .tt_in (hold_data_q),
    .pdata (w_pdata)
  );

  // Requester 1 wins when it is the only one valid, or when both are valid
  // and the round-robin pointer points at it.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant1    = req1_valid & (~req0_valid | ptr_q);
  assign w_idle      = rst_n & (state_q == ST_IDLE);

  assign req0_ready  = w_idle & w_any_valid & ~w_grant1;
  assign req1_ready  = w_idle & w_grant1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_data_d = hold_data_q;
    hold_odd_d  = hold_odd_q;
    hold_src_d  = hold_src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any_valid) begin
          hold_data_d = w_grant1 ? req1_data : req0_data;
          hold_odd_d  = w_grant1 ? req1_odd  : req0_odd;
          hold_src_d  = w_grant1;
          ptr_d       = ~w_grant1;  // next contest favours the loser
          state_d     = ST_GEN;
        end
      end
      ST_GEN: begin
        out_data_d  = w_pdata;
        out_src_d   = hold_src_q;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);  // free-running wrap
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      hold_data_q <= 7'd0;
      hold_odd_q  <= PAR_EVEN;
      hold_src_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_src_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_data_q <= hold_data_d;
      hold_odd_q  <= hold_odd_d;
      hold_src_q  <= hold_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign frame_cnt = frame_cnt_q;

endmodule : par_gen_arb
`default_nettype wire

// File: tb/tb_par_gen_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_par_gen_arb
// Purpose  : Self-checking bench for par_gen_arb (CNT_W = 2). Directed steps
//            followed by random traffic, compared against a transaction-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par_gen_arb;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_odd, req0_ready;
  logic [6:0]       req0_data;
  logic             req1_valid, req1_odd, req1_ready;
  logic [6:0]       req1_data;
  logic             out_valid, out_src, out_ready;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  par_gen_arb #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_odd   (req0_odd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_odd   (req1_odd),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .frame_cnt  (frame_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: cycles elapsed since the last accept (0 = free to
  // accept, 1 = framing, 2 = word on offer), the framed word it will show,
  // the word currently expected on the output, and the transfer count.
  int         m_age = 0;
  bit         m_ptr = 1'b0;
  logic [7:0] m_frame = 8'd0;
  bit         m_src = 1'b0;
  logic [7:0] m_outword = 8'd0;
  bit         m_outsrc = 1'b0;
  int         m_cnt = 0;
  bit         m_acc = 1'b0;

  function automatic logic [7:0] frame_of(input logic [6:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    frame_of = {(((ones + (odd ? 1 : 0)) % 2) == 1), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational readies, advance model at the edge,
  // then check registered outputs 1 ns after the edge.
  task automatic cycle();
    bit g1;
    bit e_r0, e_r1;
    #1;
    g1   = req1_valid && (!req0_valid || m_ptr);
    e_r0 = rst_n && (m_age == 0) && req0_valid && !g1;
    e_r1 = rst_n && (m_age == 0) && g1;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    m_acc = 1'b0;
    @(posedge clk);
    if (!rst_n) begin
      m_age = 0; m_ptr = 1'b0; m_outword = 8'd0; m_outsrc = 1'b0; m_cnt = 0;
    end else if (m_age == 0) begin
      if (req0_valid || req1_valid) begin
        m_acc   = 1'b1;
        m_src   = g1;
        m_frame = g1 ? frame_of(req1_data, req1_odd) : frame_of(req0_data, req0_odd);
        m_ptr   = !g1;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_outword = m_frame;
      m_outsrc  = m_src;
      m_age     = 2;
    end else if (out_ready) begin
      m_age = 0;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    #1;
    chk("out_valid", out_valid, (m_age == 2));
    chk("out_data",  out_data,  m_outword);
    chk("out_src",   out_src,   m_outsrc);
    chk("frame_cnt", frame_cnt, m_cnt);
    cyc++;
  endtask

  initial begin
    int acc_cyc[$];
    bit acc_src[$];
    int seq[5];
    int t0;

    seq = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_data = 7'd0; req0_odd = 1'b0;
    req1_valid = 1'b0; req1_data = 7'd0; req1_odd = 1'b0;

    // Reset
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;

    // req0, 0x55, even
    req0_valid = 1'b1; req0_data = 7'h55; req0_odd = 1'b0; out_ready = 1'b1;
    #1 chk("s1_ready0", req0_ready, 1'b1);
    cycle();
    req0_valid = 1'b0; req0_data = 7'h2a;
    cycle();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_data",  out_data,  8'h55);
    chk("s1_src",   out_src,   1'b0);
    cycle();
    chk("s1_cnt", frame_cnt, 1);

    // req1, 0x00, odd
    req1_valid = 1'b1; req1_data = 7'h00; req1_odd = 1'b1;
    cycle();
    req1_valid = 1'b0;
    cycle();
    chk("s2_data", out_data, 8'h80);
    chk("s2_src",  out_src,  1'b1);
    cycle();

    // Both valid continuously: alternating grants, 3 cycles apart
    req0_valid = 1'b1; req1_valid = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      req0_data = 7'($urandom); req1_data = 7'($urandom);
      req0_odd = 1'($urandom); req1_odd = 1'($urandom);
      #1;
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(cyc - t0);
        acc_src.push_back(req1_ready);
      end
      cycle();
    end
    chk("s3_accepts", acc_cyc.size(), 4);
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
      chk("s3_src",  acc_src[i], i % 2);
      chk("s3_time", acc_cyc[i], 3 * i);
    end

    // out_ready low for 5 cycles in SEND
    out_ready = 1'b0; req0_data = 7'h3c; req0_odd = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < 5; i++) begin
      req0_data = 7'($urandom); req1_data = 7'($urandom);
      req0_odd = 1'($urandom);
      cycle();
      chk("s4_hold_data",  out_data,  8'hbc);
      chk("s4_hold_valid", out_valid, 1'b1);
      chk("s4_hold_cnt",   frame_cnt, 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("s4_cnt", frame_cnt, 3);

    // Reset during SEND with out_ready high
    req1_valid = 1'b1; out_ready = 1'b0;
    cycle(); cycle();
    req1_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    cycle();
    chk("s5_valid", out_valid, 1'b0);
    chk("s5_cnt",   frame_cnt, 0);
    rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("s5_ready0", req0_ready, 1'b1);
    chk("s5_ready1", req1_ready, 1'b0);
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(); cycle();

    // Counter wrap with CNT_W = 2
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_data = 7'($urandom);
      cycle();
      req0_valid = 1'b0;
      cycle(); cycle();
      chk("s6_cnt", frame_cnt, seq[i]);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 49) != 0);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_data  = 7'($urandom); req1_data  = 7'($urandom);
      req0_odd   = 1'($urandom); req1_odd   = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_par_gen_arb
`default_nettype wire
